// File: rtl/mul8u_acc_pkg.sv
// Shared types and defaults for the mul8u product accumulation stage.
// Bias compensation is selected at compile time with MUL8U_ACC_BIAS_COMP_EN.
package mul8u_acc_pkg;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_e;

    localparam int PROD_W    = 16;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_BIAS  = 3;

endpackage

// File: rtl/mul8u_acc_adder.sv
// Combinational accumulator adder: zero-extends the product, optionally adds BIAS,
// and reports the carry out of the ACC_W-bit sum. Bias add enabled by MUL8U_ACC_BIAS_COMP_EN.
module mul8u_acc_adder
    import mul8u_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int BIAS  = DEF_BIAS
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

`ifdef MUL8U_ACC_BIAS_COMP_EN
    localparam logic [ACC_W:0] BIAS_TERM = (ACC_W+1)'(BIAS);
`else
    // BIAS stays in the parameter list so both builds share one interface.
    localparam logic [ACC_W:0] BIAS_TERM = (ACC_W+1)'(BIAS) & {(ACC_W+1){1'b0}};
`endif

    logic [ACC_W:0] term_s;
    logic [ACC_W:0] total_s;

    // Term formation and one extra bit of headroom to capture the carry.
    always_comb begin
        term_s  = {{(ACC_W+1-PROD_W){1'b0}}, prod} + BIAS_TERM;
        total_s = {1'b0, acc} + term_s;
    end

    assign sum   = total_s[ACC_W-1:0];
    assign carry = total_s[ACC_W];

endmodule

// File: rtl/mul8u_acc_stage.sv
// Frame accumulator for 16-bit multiplier products with a registered per-frame result.
// Define MUL8U_ACC_BIAS_COMP_EN to add BIAS to every accepted product.
module mul8u_acc_stage
    import mul8u_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int BIAS  = DEF_BIAS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    acc_state_e       state_r;
    acc_state_e       state_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] sum_s;
    logic             carry_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             cnt_wrap_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             accept_s;
    logic             release_s;

    mul8u_acc_adder #(
        .ACC_W (ACC_W),
        .BIAS  (BIAS)
    ) u_adder (
        .acc   (acc_r),
        .prod  (in_prod),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // Handshake qualifiers and per-beat counter / overflow update values.
    always_comb begin
        accept_s   = in_valid && (state_r == ST_ACC);
        release_s  = out_valid && out_ready && (state_r == ST_HOLD);
        cnt_inc_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        cnt_wrap_s = &cnt_r;
        ovf_nxt_s  = ovf_r | carry_s | cnt_wrap_s;
    end

    // Next-state logic for the ACC/HOLD frame FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ACC: begin
                if (accept_s && in_last) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (release_s) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_ACC;
        endcase
    end

    // State, accumulator and output registers; in_ready is registered from the next state
    // so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_ACC;
            in_ready  <= 1'b1;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= {ACC_W{1'b0}};
            out_count <= {CNT_W{1'b0}};
            out_ovf   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            in_ready <= (state_nxt_s == ST_ACC);
            if (accept_s) begin
                if (in_last) begin
                    out_sum   <= sum_s;
                    out_count <= cnt_inc_s;
                    out_ovf   <= ovf_nxt_s;
                    out_valid <= 1'b1;
                    acc_r     <= {ACC_W{1'b0}};
                    cnt_r     <= {CNT_W{1'b0}};
                    ovf_r     <= 1'b0;
                end else begin
                    acc_r <= sum_s;
                    cnt_r <= cnt_inc_s;
                    ovf_r <= ovf_nxt_s;
                end
            end else if (release_s) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

endmodule
